ntt_result_collector: RTL and testbench



---
 rtl/ntt_result_collector.sv | 116 +++++++++++
 tb/tb_ntt_result_collector.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_result_collector.sv
// Ping-pong result collector for the NTT systolic array: captures N row sums mod Q, streams them out.
// Optional NTT_BITREV_EN: emit coefficients in bit-reversed index order instead of natural order.
module ntt_result_collector #(
    parameter int unsigned N  = 16,
    parameter int unsigned Q  = 7681,
    parameter int unsigned W  = 32,
    parameter int unsigned IW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [IW-1:0]   out_index,
    output logic            out_last,
    output logic [15:0]     frame_count
);

    localparam logic [W-1:0]  QW      = W'(Q);
    localparam logic [IW-1:0] LastCnt = IW'(N - 1);

    logic [W-1:0]  bank_q [2][N];
    logic [W-1:0]  red    [N];
    logic [1:0]    bank_full_q, bank_full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [IW-1:0] rd_cnt_q, rd_cnt_d;
    logic [IW-1:0] rd_idx;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          capture, pop, last_pop;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            red[i] = in_data[i*W +: W] % QW;
        end
    end

`ifdef NTT_BITREV_EN
    always_comb begin
        rd_idx = '0;
        for (int b = 0; b < int'(IW); b++) begin
            rd_idx[b] = rd_cnt_q[IW-1-b];
        end
    end
`else
    assign rd_idx = rd_cnt_q;
`endif

    // Ready depends only on registered bank state, never on out_ready.
    assign in_ready    = !bank_full_q[wr_sel_q];
    assign out_valid   = bank_full_q[rd_sel_q];
    assign out_data    = bank_q[rd_sel_q][rd_idx];
    assign out_index   = rd_idx;
    assign out_last    = out_valid && (rd_cnt_q == LastCnt);
    assign frame_count = frame_count_q;

    assign capture  = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign last_pop = pop && (rd_cnt_q == LastCnt);

    always_comb begin
        bank_full_d   = bank_full_q;
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        rd_cnt_d      = rd_cnt_q;
        frame_count_d = frame_count_q;
        // A capture bank is always empty and a pop bank always full, so the two never collide.
        if (capture) begin
            bank_full_d[wr_sel_q] = 1'b1;
            wr_sel_d              = !wr_sel_q;
        end
        if (pop) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (last_pop) begin
            rd_cnt_d              = '0;
            bank_full_d[rd_sel_q] = 1'b0;
            rd_sel_d              = !rd_sel_q;
            frame_count_d         = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full_q   <= '0;
            wr_sel_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            rd_cnt_q      <= '0;
            frame_count_q <= '0;
        end else begin
            bank_full_q   <= bank_full_d;
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            rd_cnt_q      <= rd_cnt_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(N); i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (capture) begin
            for (int i = 0; i < int'(N); i++) begin
                bank_q[wr_sel_q][i] <= red[i];
            end
        end
    end

endmodule

// File: tb/tb_ntt_result_collector.sv
// Randomised self-checking bench for ntt_result_collector against a queue-based reference model.
module tb_ntt_result_collector;

    localparam int N  = 16;
    localparam int W  = 32;
    localparam int IW = 4;
    localparam logic [31:0] QV = 32'd7681;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_index;
    logic           out_last;
    logic [15:0]    frame_count;

    ntt_result_collector #(.N(N), .Q(7681), .W(W), .IW(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Reference model: flat queue of pending coefficients in emit order.
    logic [W-1:0] m_data[$];
    int           m_idx[$];
    bit           m_last[$];
    int           m_fc;
    int           n_vec;
    int           n_err;

    function automatic int emit_idx(input int k);
`ifdef NTT_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < IW; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (IW - 1 - b));
        end
        return r;
`else
        return k;
`endif
    endfunction

    // Advance the model by one clock using the driven inputs, then move to the next sample point.
    task automatic tick();
        bit acc;
        bit popd;
        int idx;
        if (rst) begin
            m_data.delete();
            m_idx.delete();
            m_last.delete();
            m_fc = 0;
        end else begin
            acc  = in_valid && (m_data.size() <= N);
            popd = out_ready && (m_data.size() > 0);
            if (popd) begin
                if (m_last[0]) m_fc = (m_fc + 1) % 65536;
                void'(m_data.pop_front());
                void'(m_idx.pop_front());
                void'(m_last.pop_front());
            end
            if (acc) begin
                for (int k = 0; k < N; k++) begin
                    idx = emit_idx(k);
                    m_data.push_back(in_data[idx*W +: W] % QV);
                    m_idx.push_back(idx);
                    m_last.push_back(k == N - 1);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({in_ready, out_valid, out_last, out_index, out_data, frame_count} !==
            {1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_in: rdy=%b vld=%b last=%b idx=%0d data=%0d fc=%0d want 1 0 0 0 0 0",
                     in_ready, out_valid, out_last, out_index, out_data, frame_count);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if ({in_ready, out_valid, out_last, out_index, out_data, frame_count} !==
            {1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_after: rdy=%b vld=%b last=%b idx=%0d data=%0d fc=%0d want 1 0 0 0 0 0",
                     in_ready, out_valid, out_last, out_index, out_data, frame_count);
        end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(7681 + i);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if ({out_valid, out_index, out_last, out_data} !==
                {1'b1, 4'(m_idx[0]), m_last[0], m_data[0]}) begin
                n_err++;
                $display("FAIL single_frame[%0d]: got vld=%b idx=%0d last=%b data=%0d want 1 %0d %b %0d",
                         k, out_valid, out_index, out_last, out_data, m_idx[0], m_last[0], m_data[0]);
            end
            tick();
        end
        n_vec++;
        if ({out_valid, frame_count} !== {1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL single_frame_done: vld=%b fc=%0d want 0 1", out_valid, frame_count);
        end
    endtask

    task automatic test_reduction();
        logic [31:0] big;
        logic [31:0] want [4];
        big = 32'hFFFF_FFFF;
        want[0] = 32'd7665;
        want[1] = 32'd7680;
        want[2] = 32'd0;
        want[3] = big % QV;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
        in_data[0*W +: W] = 32'd122880;
        in_data[1*W +: W] = 32'd7680;
        in_data[2*W +: W] = 32'd7681;
        in_data[3*W +: W] = big;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if ({out_valid, out_index, out_data} !== {1'b1, 4'(m_idx[0]), m_data[0]}) begin
                n_err++;
                $display("FAIL reduction[%0d]: got idx=%0d data=%0d want %0d %0d",
                         k, out_index, out_data, m_idx[0], m_data[0]);
            end
            if (m_idx[0] < 4) begin
                n_vec++;
                if (out_data !== want[m_idx[0]]) begin
                    n_err++;
                    $display("FAIL reduction_bound[%0d]: got %0d want %0d",
                             m_idx[0], out_data, want[m_idx[0]]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'd5;
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'd9;
        tick();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'd7;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if ({in_ready, out_valid, out_index, out_data} !== {1'b0, 1'b1, 4'd0, 32'd5}) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: rdy=%b vld=%b idx=%0d data=%0d want 0 1 0 5",
                         c, in_ready, out_valid, out_index, out_data);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2 * N; k++) begin
            n_vec++;
            if ({in_ready, out_valid, out_data, out_index, out_last} !==
                {k >= N, 1'b1, (k < N) ? 32'd5 : 32'd9, 4'(m_idx[0]), m_last[0]}) begin
                n_err++;
                $display("FAIL backpressure_drain[%0d]: rdy=%b vld=%b data=%0d idx=%0d last=%b",
                         k, in_ready, out_valid, out_data, out_index, out_last);
            end
            tick();
        end
        n_vec++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL backpressure_empty: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom_range(122880, 0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, frame_count} !== {1'b0, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL mid_reset: vld=%b rdy=%b fc=%0d want 0 1 0", out_valid, in_ready, frame_count);
        end
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if ({out_valid, out_index, out_last, out_data} !==
                {1'b1, 4'(m_idx[0]), m_last[0], m_data[0]}) begin
                n_err++;
                $display("FAIL mid_reset_frame[%0d]: got idx=%0d last=%b data=%0d want %0d %b %0d",
                         k, out_index, out_last, out_data, m_idx[0], m_last[0], m_data[0]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit ev;
        for (int c = 0; c < 800; c++) begin
            ev = (m_data.size() > 0);
            n_vec++;
            if ({out_valid, in_ready, frame_count} !== {ev, m_data.size() <= N, 16'(m_fc)}) begin
                n_err++;
                $display("FAIL random_ctl[%0d]: vld=%b rdy=%b fc=%0d want %b %b %0d",
                         c, out_valid, in_ready, frame_count, ev, m_data.size() <= N, m_fc);
            end
            if (ev) begin
                n_vec++;
                if ({out_index, out_last, out_data} !== {4'(m_idx[0]), m_last[0], m_data[0]}) begin
                    n_err++;
                    $display("FAIL random_data[%0d]: idx=%0d last=%b data=%0d want %0d %b %0d",
                             c, out_index, out_last, out_data, m_idx[0], m_last[0], m_data[0]);
                end
            end
            in_valid = ($urandom_range(2, 0) == 0);
            for (int i = 0; i < N; i++) begin
                in_data[i*W +: W] = ($urandom_range(1, 0) == 0) ? $urandom : $urandom_range(122880, 0);
            end
            out_ready = ($urandom_range(3, 0) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 2 * N + 2; c++) tick();
        n_vec++;
        if ({out_valid, in_ready, frame_count} !== {1'b0, 1'b1, 16'(m_fc)}) begin
            n_err++;
            $display("FAIL random_drain: vld=%b rdy=%b fc=%0d want 0 1 %0d",
                     out_valid, in_ready, frame_count, m_fc);
        end
    endtask

`ifdef NTT_BITREV_EN
    task automatic test_bitrev();
        int br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(i);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if ({out_valid, out_index, out_data, out_last} !==
                {1'b1, 4'(br[k]), 32'(br[k]), k == N - 1}) begin
                n_err++;
                $display("FAIL bitrev[%0d]: idx=%0d data=%0d last=%b want %0d %0d %b",
                         k, out_index, out_data, out_last, br[k], br[k], k == N - 1);
            end
            tick();
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        m_fc = 0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_reduction();
        test_backpressure();
        test_mid_reset();
        test_random();
`ifdef NTT_BITREV_EN
        test_bitrev();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
